// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared constants for the multi-cycle MIPS control unit:
//   - opcode values of the supported instructions
//   - state encodings of the control FSM (also exported on the debug port)
//   - ALU operation codes and the ALU B-operand / PC-source mux selects
//   - helper functions for opcode legality and memory-wait states
// ---------------------------------------------------------------------------
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
    localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_LUI};
    endfunction

    // States that hold a memory request open until mem_ready arrives.
    function automatic logic is_wait_state(input state_t s);
        return s inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles a memory state has waited for mem_ready and
// flags the cycle on which the wait must be abandoned.
// Ports:
//   clk     in   clock
//   rstn    in   asynchronous active-low reset
//   clear   in   restart the count from zero on the next edge
//   enable  in   this cycle is a waiting cycle (wait state, mem_ready low)
//   timeout out  this waiting cycle is the last one allowed
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int WAIT_CNT_W   = $clog2(WAIT_TIMEOUT)
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [WAIT_CNT_W-1:0] wait_cnt;

    assign timeout = enable && (wait_cnt == WAIT_CNT_W'(WAIT_TIMEOUT - 1));

    // The timeout cycle also restarts the count, so a retried fetch gets a
    // full fresh wait window even though the state does not change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (clear || timeout) begin
            wait_cnt <= '0;
        end else if (enable) begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/multi_cycle_control.sv
// ---------------------------------------------------------------------------
// multi_cycle_control
// Control FSM of the multi-cycle MIPS datapath. One micro-step per clock;
// memory states wait on mem_ready and give up after WAIT_TIMEOUT cycles.
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   opcode                 IR[31:26], meaningful from S_DECODE onward
//   mem_ready              memory finishes the current access this cycle
//   pc_write/pc_write_cond PC load (unconditional / on ALU zero)
//   i_or_d                 memory address select (0 PC, 1 ALUOut)
//   mem_read/mem_write     memory requests
//   ir_write               IR load
//   mem_to_reg/reg_dst     register write data / destination selects
//   reg_write              register file write
//   lui                    immediate path selects {imm,16'b0}
//   alu_src_a/alu_src_b    ALU operand selects
//   alu_op                 ALU operation (add/sub/funct)
//   pc_source              next-PC select
//   state                  current FSM state (debug)
//   illegal_instr          pulse on an undecodable opcode in S_DECODE
//   bus_err                registered pulse the cycle after a memory timeout
// ---------------------------------------------------------------------------
module multi_cycle_control
    import mc_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16,
    parameter int WAIT_CNT_W   = $clog2(WAIT_TIMEOUT)
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       lui,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_instr,
    output logic       bus_err
);

    state_t state_q;
    state_t next_state;
    logic   in_wait;
    logic   timeout;

    logic   pc_write_raw;
    logic   pc_write_cond_raw;
    logic   mem_write_raw;
    logic   ir_write_raw;
    logic   reg_write_raw;

    assign state   = state_q;
    assign in_wait = is_wait_state(state_q);

    // Leaving a wait state always passes through either a non-wait cycle or
    // a mem_ready/timeout cycle, so clearing on those covers state entry.
    mem_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .WAIT_CNT_W   (WAIT_CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (!in_wait || mem_ready),
        .enable  (in_wait && !mem_ready),
        .timeout (timeout)
    );

    always_comb begin
        next_state = S_FETCH;
        case (state_q)
            S_FETCH:     next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    next_state = S_MEM_ADDR;
                    OP_RTYPE:        next_state = S_EXEC;
                    OP_BEQ:          next_state = S_BRANCH;
                    OP_J:            next_state = S_JUMP;
                    OP_ADDI, OP_LUI: next_state = S_I_EXEC;
                    default:         next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      next_state = S_MEM_READ;
                else if (opcode == OP_SW) next_state = S_MEM_WRITE;
                else                      next_state = S_FETCH;
            end
            S_MEM_READ: begin
                if (mem_ready)    next_state = S_MEM_WB;
                else if (timeout) next_state = S_FETCH;
                else              next_state = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (mem_ready || timeout) next_state = S_FETCH;
                else                      next_state = S_MEM_WRITE;
            end
            S_EXEC:   next_state = S_R_WB;
            S_I_EXEC: next_state = S_I_WB;
            default:  next_state = S_FETCH;
        endcase
    end

    // State register plus the registered bus error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_FETCH;
            bus_err <= 1'b0;
        end else begin
            state_q <= next_state;
            bus_err <= timeout;
        end
    end

    // Control decode. A timeout cycle drops every request and strobe so the
    // abandoned access leaves no side effect in the datapath.
    always_comb begin
        pc_write_raw      = 1'b0;
        pc_write_cond_raw = 1'b0;
        mem_write_raw     = 1'b0;
        ir_write_raw      = 1'b0;
        reg_write_raw     = 1'b0;
        i_or_d            = 1'b0;
        mem_read          = 1'b0;
        mem_to_reg        = 1'b0;
        reg_dst           = 1'b0;
        lui               = 1'b0;
        alu_src_a         = 1'b0;
        alu_src_b         = ALU_SRC_B_REG;
        alu_op            = ALUOP_ADD;
        pc_source         = PC_SRC_ALU;
        illegal_instr     = 1'b0;
        if (!timeout) begin
            case (state_q)
                S_FETCH: begin
                    mem_read     = 1'b1;
                    alu_src_b    = ALU_SRC_B_FOUR;
                    ir_write_raw = mem_ready;
                    pc_write_raw = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b     = ALU_SRC_B_IMM_SH;
                    illegal_instr = !is_legal_op(opcode);
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_SRC_B_IMM;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_raw = 1'b1;
                    mem_to_reg    = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write_raw = 1'b1;
                    i_or_d        = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    reg_write_raw = 1'b1;
                    reg_dst       = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a         = 1'b1;
                    alu_op            = ALUOP_SUB;
                    pc_write_cond_raw = 1'b1;
                    pc_source         = PC_SRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write_raw = 1'b1;
                    pc_source    = PC_SRC_JUMP;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_SRC_B_IMM;
                    lui       = (opcode == OP_LUI);
                end
                S_I_WB: begin
                    reg_write_raw = 1'b1;
                    lui           = (opcode == OP_LUI);
                end
                default: ;
            endcase
        end
    end

    // Architectural write strobes are masked by reset directly so nothing
    // commits while rstn is low, even though FETCH decodes mem_ready.
    assign pc_write      = pc_write_raw      && rstn;
    assign pc_write_cond = pc_write_cond_raw && rstn;
    assign mem_write     = mem_write_raw     && rstn;
    assign ir_write      = ir_write_raw      && rstn;
    assign reg_write     = reg_write_raw     && rstn;

endmodule

// File: tb/tb_multi_cycle_control.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_control
// Builds a cycle-by-cycle plan of instructions from the opcode step sequence
// and memory wait pattern, drives it, and compares the control unit against
// the expected micro-step outputs queued alongside each stimulus cycle.
// ---------------------------------------------------------------------------
module tb_multi_cycle_control;

    localparam int WAIT_TIMEOUT = 16;

    localparam int ST_FETCH     = 0;
    localparam int ST_DECODE    = 1;
    localparam int ST_MEM_ADDR  = 2;
    localparam int ST_MEM_READ  = 3;
    localparam int ST_MEM_WB    = 4;
    localparam int ST_MEM_WRITE = 5;
    localparam int ST_EXEC      = 6;
    localparam int ST_R_WB      = 7;
    localparam int ST_BRANCH    = 8;
    localparam int ST_JUMP      = 9;
    localparam int ST_I_EXEC    = 10;
    localparam int ST_I_WB      = 11;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_LUI  = 6'h0F;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, lui, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_instr, bus_err;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        ctl_t       ctl;
        logic       mr;
        logic [5:0] op;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, lui, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_instr, bus_err;
    ctl_t       act;

    int   errors = 0;
    int   checks = 0;
    cyc_t plan[$];
    cyc_t sb[$];
    cyc_t mon_rec;
    int   mon_idx = 0;
    bit   mon_en = 1'b0;
    bit   pend_be = 1'b0;

    always #5 clk = ~clk;

    multi_cycle_control #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .lui           (lui),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .illegal_instr (illegal_instr),
        .bus_err       (bus_err)
    );

    assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, lui, alu_src_a, alu_src_b,
                  alu_op, pc_source, illegal_instr, bus_err};

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_J, OPC_ADDI, OPC_LUI};
    endfunction

    // Expected datapath controls for one micro-step, taken from the step table.
    function automatic ctl_t step_ctl(input int st, input logic [5:0] op, input logic mr);
        ctl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_read = 1'b1; c.alu_src_b = 2'b01;
                c.pc_write = mr;   c.ir_write  = mr;
            end
            ST_DECODE: begin
                c.alu_src_b = 2'b11; c.illegal_instr = !is_legal(op);
            end
            ST_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ST_MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            ST_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            ST_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            ST_EXEC:      begin c.alu_src_a = 1'b1; c.alu_op = 3'b010; end
            ST_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            ST_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 3'b001;
                c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
            end
            ST_JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            ST_I_EXEC: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.lui = (op == OPC_LUI);
            end
            ST_I_WB:      begin c.reg_write = 1'b1; c.lui = (op == OPC_LUI); end
            default: ;
        endcase
        return c;
    endfunction

    // One planned clock cycle; bus_err shows up one cycle after an abort.
    function automatic void emit(input int st, input logic mr, input logic [5:0] op, input bit abort);
        cyc_t r;
        r.st  = 4'(st);
        r.mr  = mr;
        r.op  = op;
        r.ctl = '0;
        if (!abort) r.ctl = step_ctl(st, op, mr);
        r.ctl.bus_err = pend_be;
        pend_be = abort;
        plan.push_back(r);
    endfunction

    // A memory state: n_low cycles without mem_ready, then completion, or a
    // full WAIT_TIMEOUT run of low cycles ending in an abort.
    function automatic void plan_wait(input int st, input logic [5:0] op, input int n_low, input bit to);
        int lows;
        lows = to ? WAIT_TIMEOUT : n_low;
        for (int i = 0; i < lows; i++)
            emit(st, 1'b0, (st == ST_FETCH) ? 6'($urandom) : op, to && (i == lows - 1));
        if (!to) emit(st, 1'b1, (st == ST_FETCH) ? 6'($urandom) : op, 1'b0);
    endfunction

    function automatic void plan_instr(input logic [5:0] op, input int fw, input bit ft,
                                       input int dw, input bit dt);
        plan_wait(ST_FETCH, op, fw, ft);
        if (ft) plan_wait(ST_FETCH, op, 0, 1'b0);
        emit(ST_DECODE, 1'($urandom), op, 1'b0);
        case (op)
            OPC_R: begin
                emit(ST_EXEC, 1'($urandom), op, 1'b0);
                emit(ST_R_WB, 1'($urandom), op, 1'b0);
            end
            OPC_LW: begin
                emit(ST_MEM_ADDR, 1'($urandom), op, 1'b0);
                plan_wait(ST_MEM_READ, op, dw, dt);
                if (!dt) emit(ST_MEM_WB, 1'($urandom), op, 1'b0);
            end
            OPC_SW: begin
                emit(ST_MEM_ADDR, 1'($urandom), op, 1'b0);
                plan_wait(ST_MEM_WRITE, op, dw, dt);
            end
            OPC_BEQ: emit(ST_BRANCH, 1'($urandom), op, 1'b0);
            OPC_J:   emit(ST_JUMP, 1'($urandom), op, 1'b0);
            OPC_ADDI, OPC_LUI: begin
                emit(ST_I_EXEC, 1'($urandom), op, 1'b0);
                emit(ST_I_WB, 1'($urandom), op, 1'b0);
            end
            default: ;
        endcase
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r == 6) return WAIT_TIMEOUT - 1;
        return 0;
    endfunction

    // Drive each planned cycle just after the edge and hand its expectation
    // to the monitor.
    task automatic apply_stimulus();
        cyc_t r;
        while (plan.size() > 0) begin
            r = plan.pop_front();
            opcode    = r.op;
            mem_ready = r.mr;
            sb.push_back(r);
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard underflow: got 0 entries expected at least 1");
            end else begin
                mon_rec = sb.pop_front();
                check_output($sformatf("cyc%0d state", mon_idx), 32'(state), 32'(mon_rec.st));
                check_output($sformatf("cyc%0d ctl", mon_idx), 32'(act), 32'(mon_rec.ctl));
                mon_idx++;
            end
        end
    end

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        int         k;
        ops = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_J, OPC_ADDI, OPC_LUI};

        rstn      = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        #12;
        check_output("reset state", 32'(state), 32'd0);
        check_output("reset bus_err", 32'(bus_err), 32'd0);
        check_output("reset pc_write", 32'(pc_write), 32'd0);
        check_output("reset ir_write", 32'(ir_write), 32'd0);
        check_output("reset strobes", 32'({pc_write_cond, reg_write, mem_write}), 32'd0);

        plan_instr(OPC_R,    0, 1'b0, 0, 1'b0);
        plan_instr(OPC_LW,   0, 1'b0, 3, 1'b0);
        plan_instr(OPC_SW,   0, 1'b0, 0, 1'b1);
        plan_instr(OPC_BEQ,  0, 1'b0, 0, 1'b0);
        plan_instr(OPC_J,    0, 1'b0, 0, 1'b0);
        plan_instr(6'h3F,    0, 1'b0, 0, 1'b0);
        plan_instr(OPC_LUI,  0, 1'b0, 0, 1'b0);
        plan_instr(OPC_ADDI, 2, 1'b0, 0, 1'b0);
        plan_instr(OPC_SW,   0, 1'b0, WAIT_TIMEOUT - 1, 1'b0);
        plan_instr(OPC_R,    WAIT_TIMEOUT - 1, 1'b0, 0, 1'b0);
        plan_instr(OPC_LW,   1, 1'b1, 0, 1'b0);
        plan_instr(OPC_LW,   0, 1'b0, 2, 1'b1);
        for (int n = 0; n < 40; n++) begin
            k  = $urandom_range(0, 7);
            op = (k == 7) ? 6'($urandom) : ops[k];
            plan_instr(op, pick_wait(), ($urandom_range(0, 11) == 0),
                       pick_wait(), ($urandom_range(0, 11) == 0));
        end

        @(posedge clk);
        #1;
        rstn   = 1'b1;
        mon_en = 1'b1;
        apply_stimulus();
        mon_en = 1'b0;
        check_output("scoreboard drained", 32'(sb.size()), 32'd0);

        // Store stalled in MEM_WRITE, then reset in the middle of the cycle.
        opcode    = OPC_SW;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("stall state", 32'(state), 32'(ST_MEM_WRITE));
        check_output("stall mem_write", 32'(mem_write), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_output("midreset mem_write", 32'(mem_write), 32'd0);
        check_output("midreset state", 32'(state), 32'd0);
        mem_ready = 1'b1;
        #1;
        check_output("midreset pc/ir write", 32'({pc_write, ir_write}), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        rstn      = 1'b1;
        #1;
        check_output("release state", 32'(state), 32'd0);
        check_output("release bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        check_output("post-release state", 32'(state), 32'd0);
        check_output("post-release bus_err", 32'(bus_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Moore/Mealy FSM that sequences a multi-cycle MIPS datapath: one shared instruction/data memory, IR, A/B/ALUOut/MDR latches, one ALU.
- Decodes the registered opcode and drives every datapath control strobe, one micro-step per clock.
- Tolerates variable memory latency via a mem_ready handshake with a timeout.
- Next step after the single-cycle core; the team's multi-cycle processor top instantiates it.

Parameters:
- WAIT_TIMEOUT, 16: max cycles a memory state may wait for mem_ready before aborting to fetch (must be ≥2).
- WAIT_CNT_W, $clog2(WAIT_TIMEOUT), width of the wait counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rstn  in  1  reset; asynchronous, active-low.
- opcode  in  6  IR[31:26], valid from S_DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  0 = memory address from PC, 1 = from ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  write reg: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- lui  out  1  immediate path selects {imm,16'b0}.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- alu_op  out  3  000 add, 001 sub, 010 funct-decode.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state, for debug.
- illegal_instr  out  1  one-cycle pulse on an undecodable opcode.
- bus_err  out  1  registered one-cycle pulse on a memory timeout.

Behaviour:
- Reset (rstn low, async): state = S_FETCH, wait_cnt = 0, bus_err = 0. pc_write, pc_write_cond, ir_write, reg_write and mem_write are forced 0 while rstn is low.
- Supported opcodes: R 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08, lui 0x0F.
- Outputs not listed for a state are 0.
- S_FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write and pc_write = mem_ready (Mealy).
  - Next state: DECODE if mem_ready, else stay.
- S_DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - lw/sw -> MEM_ADDR; R -> EXEC; beq -> BRANCH; j -> JUMP; addi/lui -> I_EXEC.
  - Any other opcode: illegal_instr=1 this cycle, next state FETCH.
- S_MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=000.
  - lw -> MEM_READ; sw -> MEM_WRITE.
- S_MEM_READ(3): mem_read=1, i_or_d=1.
  - mem_ready -> MEM_WB, else stay.
- S_MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- S_MEM_WRITE(5): mem_write=1, i_or_d=1, held until mem_ready.
  - mem_ready -> FETCH.
- S_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=010 -> R_WB.
- S_R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- S_BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01 -> FETCH.
- S_JUMP(9): pc_write=1, pc_source=10 -> FETCH.
- S_I_EXEC(10): alu_src_a=1, alu_src_b=10, alu_op=000; lui=1 if opcode==0x0F -> I_WB.
- S_I_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0; lui held as in I_EXEC -> FETCH.
- Codes 12–15 are unreachable; if entered, next state is FETCH.
- Zero-wait latency in cycles: R 4, lw 5, sw 4, beq 3, j 3, addi/lui 4. Each mem_ready-low cycle in a wait state adds 1.
- Wait counter, active in FETCH, MEM_READ and MEM_WRITE:
  - Clears on entering any state and whenever mem_ready=1.
  - Increments each cycle mem_ready=0.
  - When wait_cnt == WAIT_TIMEOUT-1 and mem_ready=0: next state FETCH; mem_read/mem_write and all strobes are 0 on that cycle; bus_err pulses 1 on the following cycle.
  - A timeout in FETCH retries the same PC (pc_write was never asserted).
- mem_ready on the timeout cycle itself: completion wins, normal transition, no bus_err.
- mem_ready outside wait states is ignored.
- Reset mid-instruction: immediate return to FETCH; no partial write strobe after rstn falls.

Decomposition:
- Package mc_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_LUI);
  - 4-bit state encodings S_FETCH..S_I_WB;
  - ALUOP_ADD/SUB/FUNCT;
  - ALU_SRC_B and PC_SRC codes.
- Sub-module mem_wait_timer: counter, clear/enable inputs, timeout output; holds the WAIT_TIMEOUT logic.
- The FSM stays in multi_cycle_control.

Test Plan:
- Reset release, mem_ready=1, opcode=0x00 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; pc_write=1 only in cycle 0.
- lw (0x23), mem_ready held 0 for 3 cycles in MEM_READ -> 8-cycle instruction, mem_read/i_or_d=1 throughout state 3, then reg_write=1 with mem_to_reg=1.
- sw (0x2B), mem_ready=0 for WAIT_TIMEOUT=16 cycles -> abort to FETCH on cycle 16 of the wait, bus_err=1 for exactly the next cycle, reg_write never 1.
- beq (0x04) then j (0x02) -> 3 cycles each; pc_write_cond=1 with pc_source=01 in state 8; pc_write=1 with pc_source=10 in state 9.
- opcode 0x3F in DECODE -> illegal_instr=1 for one cycle, next state FETCH; lui (0x0F) -> lui=1 in states 10–11.
- rstn dropped during MEM_WRITE with mem_ready=0 -> mem_write=0 immediately; state=0 and bus_err=0 after rstn rises.
